// File: rtl/cobs_encoder.sv
// rtl/cobs_encoder.sv - COBS encoder: framed raw bytes in, zero-free groups plus 0x00 delimiter out.
// One 254-byte group buffer; input is held off while a group is being emitted.
module cobs_encoder (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] raw_stream_tdata,
   input  logic       raw_stream_tvalid,
   output logic       raw_stream_tready,
   input  logic       raw_stream_tlast,
   output logic [7:0] encoded_stream_tdata,
   output logic       encoded_stream_tvalid,
   input  logic       encoded_stream_tready,
   output logic       encoded_stream_tlast
);

   localparam logic [7:0] MAX_RUN = 8'd254;

   typedef enum logic [2:0] {
      FILL,
      EMIT_CODE,
      EMIT_DATA,
      EMIT_TRAILER,
      EMIT_DELIM
   } state_t;

   state_t     state, state_n;
   logic [7:0] count, count_n;
   logic [7:0] rd_idx, rd_idx_n;
   logic       trailer_pending, trailer_pending_n;
   logic       frame_end, frame_end_n;
   logic [7:0] tdata_n;
   logic       tvalid_n, tlast_n;
   logic [7:0] grp_buf [0:253];
   logic       wr_en, accept, fire, close, group_done;
   logic [7:0] code, count_inc;

   assign raw_stream_tready = (state == FILL) && !rst;
   assign accept            = raw_stream_tready && raw_stream_tvalid;
   assign fire              = encoded_stream_tvalid && encoded_stream_tready;
   assign count_inc         = count + 8'd1;

   always_comb begin
      state_n           = state;
      count_n           = count;
      rd_idx_n          = rd_idx;
      trailer_pending_n = trailer_pending;
      frame_end_n       = frame_end;
      tvalid_n          = encoded_stream_tvalid;
      tdata_n           = encoded_stream_tdata;
      tlast_n           = encoded_stream_tlast;
      wr_en             = 1'b0;
      close             = 1'b0;
      code              = 8'h00;
      group_done        = 1'b0;

      case (state)
         FILL: begin
            if (accept) begin
               if (raw_stream_tdata == 8'h00) begin
                  close             = 1'b1;
                  code              = count_inc;
                  trailer_pending_n = raw_stream_tlast;
               end else begin
                  wr_en   = 1'b1;
                  count_n = count_inc;
                  // A full run carries no implied zero, so it never forces a trailer group.
                  if (count_inc == MAX_RUN) begin
                     close       = 1'b1;
                     code        = 8'hFF;
                     frame_end_n = raw_stream_tlast;
                  end else if (raw_stream_tlast) begin
                     close       = 1'b1;
                     code        = count_inc + 8'd1;
                     frame_end_n = 1'b1;
                  end
               end
            end
            if (close) begin
               state_n  = EMIT_CODE;
               tvalid_n = 1'b1;
               tdata_n  = code;
               tlast_n  = 1'b0;
            end
         end
         EMIT_CODE: begin
            if (fire) begin
               if (count != 8'd0) begin
                  tdata_n  = grp_buf[8'd0];
                  rd_idx_n = 8'd1;
                  state_n  = EMIT_DATA;
               end else begin
                  group_done = 1'b1;
               end
            end
         end
         EMIT_DATA: begin
            if (fire) begin
               if (rd_idx == count) begin
                  group_done = 1'b1;
               end else begin
                  tdata_n  = grp_buf[rd_idx];
                  rd_idx_n = rd_idx + 8'd1;
               end
            end
         end
         EMIT_TRAILER: begin
            if (fire) begin
               tdata_n = 8'h00;
               tlast_n = 1'b1;
               state_n = EMIT_DELIM;
            end
         end
         EMIT_DELIM: begin
            if (fire) begin
               tvalid_n          = 1'b0;
               tdata_n           = 8'h00;
               tlast_n           = 1'b0;
               count_n           = 8'd0;
               trailer_pending_n = 1'b0;
               frame_end_n       = 1'b0;
               state_n           = FILL;
            end
         end
         default: state_n = FILL;
      endcase

      // The next byte is loaded on the same handshake that retires the last one.
      if (group_done) begin
         if (trailer_pending) begin
            tdata_n = 8'h01;
            state_n = EMIT_TRAILER;
         end else if (frame_end) begin
            tdata_n = 8'h00;
            tlast_n = 1'b1;
            state_n = EMIT_DELIM;
         end else begin
            tvalid_n = 1'b0;
            tdata_n  = 8'h00;
            count_n  = 8'd0;
            state_n  = FILL;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state                 <= FILL;
         count                 <= 8'd0;
         rd_idx                <= 8'd0;
         trailer_pending       <= 1'b0;
         frame_end             <= 1'b0;
         encoded_stream_tvalid <= 1'b0;
         encoded_stream_tdata  <= 8'h00;
         encoded_stream_tlast  <= 1'b0;
      end else begin
         state                 <= state_n;
         count                 <= count_n;
         rd_idx                <= rd_idx_n;
         trailer_pending       <= trailer_pending_n;
         frame_end             <= frame_end_n;
         encoded_stream_tvalid <= tvalid_n;
         encoded_stream_tdata  <= tdata_n;
         encoded_stream_tlast  <= tlast_n;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         grp_buf[count] <= raw_stream_tdata;
      end
   end

endmodule
